// File: rtl/column_rasterizer.sv
// Turns one ray result per column into SCREEN_HEIGHT frame-buffer writes (ceiling, wall, floor).
// Optional `SIDE_SHADE_EN: wall pixels of y-side hits use the darker palette half (colour | 8'h80).
module column_rasterizer #(
  parameter int         SCREEN_WIDTH  = 320,
  parameter int         SCREEN_HEIGHT = 180,
  parameter logic [7:0] CEILING_COLOR = 8'd1,
  parameter logic [7:0] FLOOR_COLOR   = 8'd2
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        ray_valid_in,
  output logic        ray_ready_out,
  input  logic [8:0]  ray_col_in,
  input  logic [7:0]  ray_height_in,
  input  logic [7:0]  ray_color_in,
  input  logic        ray_side_in,
  input  logic [1:0]  fb_ready_to_switch_in,
  output logic        pixel_valid_out,
  output logic [15:0] ray_address_out,
  output logic [7:0]  ray_pixel_out,
  output logic        ray_last_pixel_out
);

  typedef enum logic [1:0] {IDLE, DRAW, WAIT_SWAP} state_t;

  localparam logic [8:0]  LAST_COL   = 9'(SCREEN_WIDTH - 1);
  localparam logic [7:0]  HEIGHT     = 8'(SCREEN_HEIGHT);
  localparam logic [7:0]  LAST_ROW   = 8'(SCREEN_HEIGHT - 1);
  localparam logic [15:0] ROW_STRIDE = 16'(SCREEN_WIDTH);

  state_t      state, state_next;
  logic [8:0]  col;
  logic [7:0]  color;
  logic [7:0]  start_row, end_row, row;
  logic        seen;
  logic        accept, col_in_range, last_row, swap_done;
  logic [7:0]  clamp_h, wall_pixel, pixel_next;
  logic [15:0] address_next;

  assign ray_ready_out = (state == IDLE) && !rst_in;
  assign accept        = ray_valid_in && ray_ready_out;
  assign col_in_range  = ray_col_in <= LAST_COL;
  assign last_row      = row == LAST_ROW;
  assign swap_done     = seen && (fb_ready_to_switch_in == 2'b00);
  assign clamp_h       = (ray_height_in > HEIGHT) ? HEIGHT : ray_height_in;
  assign address_next  = 16'(col) + ROW_STRIDE * 16'(row);

`ifdef SIDE_SHADE_EN
  logic side;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in)      side <= 1'b0;
    else if (accept) side <= ray_side_in;
  end

  assign wall_pixel = side ? (color | 8'h80) : color;
`else
  logic unused_side;

  assign unused_side = ray_side_in;
  assign wall_pixel  = color;
`endif

  always_comb begin
    pixel_next = FLOOR_COLOR;
    if (row < start_row)    pixel_next = CEILING_COLOR;
    else if (row < end_row) pixel_next = wall_pixel;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Out-of-range columns are consumed in IDLE without ever entering DRAW.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept && col_in_range) state_next = DRAW;
      DRAW:      if (last_row) state_next = (col == LAST_COL) ? WAIT_SWAP : IDLE;
      WAIT_SWAP: if (swap_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pixel_valid_out    <= 1'b0;
      ray_address_out    <= '0;
      ray_pixel_out      <= '0;
      ray_last_pixel_out <= 1'b0;
      seen               <= 1'b0;
      row                <= '0;
      col                <= '0;
      color              <= '0;
      start_row          <= '0;
      end_row            <= '0;
    end else begin
      pixel_valid_out    <= 1'b0;
      ray_last_pixel_out <= 1'b0;
      if (accept) begin
        col       <= ray_col_in;
        color     <= ray_color_in;
        start_row <= (HEIGHT - clamp_h) >> 1;
        end_row   <= ((HEIGHT - clamp_h) >> 1) + clamp_h;
        row       <= '0;
      end
      if (state == DRAW) begin
        pixel_valid_out    <= 1'b1;
        ray_address_out    <= address_next;
        ray_pixel_out      <= pixel_next;
        ray_last_pixel_out <= last_row && (col == LAST_COL);
        row                <= row + 8'd1;
      end
      // The writer-done bit must be seen before an all-clear counts as a completed swap.
      seen <= (state == WAIT_SWAP) &&
              (fb_ready_to_switch_in[0] || (seen && fb_ready_to_switch_in != 2'b00));
    end
  end

endmodule

// File: tb/tb_column_rasterizer.sv
// Self-checking bench for column_rasterizer: directed and random rays against a row-rule model.
module tb_column_rasterizer;

  localparam int W = 320;
  localparam int H = 180;
`ifdef SIDE_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ray_valid;
  logic        ray_ready;
  logic [8:0]  ray_col;
  logic [7:0]  ray_height;
  logic [7:0]  ray_color;
  logic        ray_side;
  logic [1:0]  fb_switch;
  logic        pixel_valid;
  logic [15:0] address;
  logic [7:0]  pixel;
  logic        last_pixel;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  column_rasterizer dut (
    .pixel_clk_in         (clk),
    .rst_in               (rst),
    .ray_valid_in         (ray_valid),
    .ray_ready_out        (ray_ready),
    .ray_col_in           (ray_col),
    .ray_height_in        (ray_height),
    .ray_color_in         (ray_color),
    .ray_side_in          (ray_side),
    .fb_ready_to_switch_in(fb_switch),
    .pixel_valid_out      (pixel_valid),
    .ray_address_out      (address),
    .ray_pixel_out        (pixel),
    .ray_last_pixel_out   (last_pixel)
  );

  // Expected colour of a row, straight from the ceiling/wall/floor rule.
  function automatic logic [7:0] model_pixel(input int h_in, input logic [7:0] c, input logic s,
                                             input int r);
    int h, start;
    h     = (h_in > H) ? H : h_in;
    start = (H - h) / 2;
    if (r < start)          return 8'd1;
    else if (r < start + h) return (SHADE && s) ? (c | 8'h80) : c;
    else                    return 8'd2;
  endfunction

  task automatic test_column(input int c, input int h, input logic [7:0] colr, input logic s);
    logic [7:0] exp_pix;
    logic       exp_last, exp_ready;
    checks++;
    if (ray_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_before_accept col=%0d: got %b, expected 1", c, ray_ready);
    end
    ray_valid = 1'b1; ray_col = 9'(c); ray_height = 8'(h); ray_color = colr; ray_side = s;
    @(posedge clk); #1;
    ray_valid = 1'b0; ray_col = 9'($urandom); ray_height = 8'($urandom);
    ray_color = 8'($urandom); ray_side = 1'($urandom);
    for (int r = 0; r < H; r++) begin
      @(posedge clk); #1;
      exp_pix   = model_pixel(h, colr, s, r);
      exp_last  = (c == W - 1) && (r == H - 1);
      exp_ready = (r == H - 1) && (c != W - 1);
      checks++;
      if (pixel_valid !== 1'b1 || address !== 16'(c + W * r) || pixel !== exp_pix ||
          last_pixel !== exp_last) begin
        fails++;
        $display("[TB] FAIL pixel col=%0d row=%0d: got v=%b a=%0d p=%h l=%b, expected v=1 a=%0d p=%h l=%b",
                 c, r, pixel_valid, address, pixel, last_pixel, c + W * r, exp_pix, exp_last);
      end
      checks++;
      if (ray_ready !== exp_ready) begin
        fails++;
        $display("[TB] FAIL ready_during_draw col=%0d row=%0d: got %b, expected %b",
                 c, r, ray_ready, exp_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ray_valid = 1'b0; fb_switch = 2'b00;
    ray_col = '0; ray_height = '0; ray_color = '0; ray_side = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pixel_valid !== 1'b0 || address !== 16'd0 || pixel !== 8'd0 || last_pixel !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got v=%b a=%0d p=%h l=%b, expected all zero",
               pixel_valid, address, pixel, last_pixel);
    end
    checks++;
    if (ray_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_in_reset: got %b, expected 0", ray_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (ray_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_reset: got %b, expected 1", ray_ready);
    end
  endtask

  task automatic test_directed;
    test_column(5, 60, 8'h07, 1'b0);
    test_column(0, 61, 8'h33, 1'b1);
    test_column(1, 200, 8'h07, 1'b1);
    test_column(7, 100, 8'h07, 1'b1);
    test_column(318, 180, 8'h5a, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (pixel_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL valid_after_column: got %b, expected 0", pixel_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      test_column(int'($urandom_range(0, W - 2)), int'($urandom_range(0, 255)),
                  8'($urandom), 1'($urandom));
  endtask

  task automatic test_drop;
    for (int i = 0; i < 2; i++) begin
      ray_valid = 1'b1;
      ray_col = (i == 0) ? 9'd400 : 9'($urandom_range(W, 511));
      ray_height = 8'($urandom); ray_color = 8'($urandom);
      @(posedge clk); #1;
      ray_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        checks++;
        if (pixel_valid !== 1'b0 || ray_ready !== 1'b1) begin
          fails++;
          $display("[TB] FAIL dropped_col cycle=%0d: got v=%b rdy=%b, expected v=0 rdy=1",
                   k, pixel_valid, ray_ready);
        end
      end
    end
  endtask

  task automatic test_last_column;
    logic [1:0] seq [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11};
    test_column(W - 1, 0, 8'($urandom), 1'($urandom));
    for (int k = 0; k < 7; k++) begin
      fb_switch = seq[k];
      @(posedge clk); #1;
      checks++;
      if (ray_ready !== 1'b0 || pixel_valid !== 1'b0 || last_pixel !== 1'b0) begin
        fails++;
        $display("[TB] FAIL wait_swap step=%0d: got rdy=%b v=%b l=%b, expected 0 0 0",
                 k, ray_ready, pixel_valid, last_pixel);
      end
    end
    fb_switch = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (ray_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_swap: got %b, expected 1", ray_ready);
    end
    test_column(2, 90, 8'hc4, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_pix;
    ray_valid = 1'b1; ray_col = 9'd10; ray_height = 8'd90; ray_color = 8'h44; ray_side = 1'b1;
    @(posedge clk); #1;
    ray_valid = 1'b0;
    for (int r = 0; r <= 50; r++) begin
      @(posedge clk); #1;
      exp_pix = model_pixel(90, 8'h44, 1'b1, r);
      checks++;
      if (pixel_valid !== 1'b1 || address !== 16'(10 + W * r) || pixel !== exp_pix) begin
        fails++;
        $display("[TB] FAIL partial_col row=%0d: got v=%b a=%0d p=%h, expected v=1 a=%0d p=%h",
                 r, pixel_valid, address, pixel, 10 + W * r, exp_pix);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pixel_valid !== 1'b0 || address !== 16'd0 || pixel !== 8'd0 || last_pixel !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_draw_reset: got v=%b a=%0d p=%h l=%b, expected all zero",
               pixel_valid, address, pixel, last_pixel);
    end
    rst = 1'b0; #1;
    checks++;
    if (ray_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_mid_reset: got %b, expected 1", ray_ready);
    end
    test_column(int'($urandom_range(0, W - 2)), int'($urandom_range(0, 255)),
                8'($urandom), 1'($urandom));
    test_column(W - 1, 181, 8'h19, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (ray_ready !== 1'b1 || pixel_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wait_swap_reset: got rdy=%b v=%b, expected rdy=1 v=0",
               ray_ready, pixel_valid);
    end
    test_column(3, 45, 8'h0f, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_drop();
    test_last_column();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
